// File: rtl/aes_pkg.sv
// Shared AES constants: scheduler state encoding and round parameters.
// The key schedule reuses AES_NR / AES_RND_W, so keep them here.
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_RND_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/aes_nch_sched_if.sv
// Requester/core-side bundle of the N-channel AES scheduler.
// The master side (requester) drives start/chan_req. The slave side
// (the scheduler) drives everything else.
interface aes_nch_sched_if #(
   parameter int N = 4
);
   localparam int CW = $clog2(N);

   logic          start;
   logic [N-1:0]  chan_req;
   logic          busy;
   logic [N-1:0]  grant_mask;
   logic          load_en;
   logic [CW-1:0] load_sel;
   logic          accept;
   logic [3:0]    rndNo;
   logic          enbSB;
   logic          enbSR;
   logic          enbMC;
   logic          enbAR;
   logic          enbKS;
   logic          out_valid;
   logic [CW-1:0] out_chan;
   logic          done;

   modport master (
      output start, chan_req,
      input  busy, grant_mask, load_en, load_sel, accept, rndNo,
             enbSB, enbSR, enbMC, enbAR, enbKS, out_valid, out_chan, done
   );

   modport slave (
      input  start, chan_req,
      output busy, grant_mask, load_en, load_sel, accept, rndNo,
             enbSB, enbSR, enbMC, enbAR, enbKS, out_valid, out_chan, done
   );

endinterface

// File: rtl/aes_slot_round_cnt.sv
// Slot/round counter pair for the interleaved AES core.
// The slot walks 0..N-1 and wraps. When round_en is set, each wrap
// advances the round. The round returns to 0 after NR, so it never
// exceeds NR.
module aes_slot_round_cnt
   import aes_pkg::*;
#(
   parameter int N  = 4,
   parameter int NR = AES_NR,
   localparam int CW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 step,
   input  logic                 round_en,
   output logic [CW-1:0]        slot,
   output logic [AES_RND_W-1:0] round,
   output logic                 slot_last,
   output logic                 round_last
);

   logic [CW-1:0]        slot_r;
   logic [AES_RND_W-1:0] round_r;

   assign slot       = slot_r;
   assign round      = round_r;
   assign slot_last  = (slot_r == CW'(N - 1));
   assign round_last = (round_r == AES_RND_W'(NR));

   // Advance slot every step; advance round on slot wrap when enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_r  <= '0;
         round_r <= '0;
      end else if (clr) begin
         slot_r  <= '0;
         round_r <= '0;
      end else if (step) begin
         if (slot_last) begin
            slot_r <= '0;
            if (round_en) begin
               round_r <= round_last ? '0 : round_r + AES_RND_W'(1);
            end else begin
               round_r <= round_r;
            end
         end else begin
            slot_r  <= slot_r + CW'(1);
            round_r <= round_r;
         end
      end else begin
         slot_r  <= slot_r;
         round_r <= round_r;
      end
   end

endmodule

// File: rtl/aes_nch_sched.sv
// Sequencer/channel scheduler for the N-channel interleaved AES-128 core.
// It snapshots a request vector and then steps the core through three
// phases: load, initial AddRoundKey, and rounds 1..NR.
// Outputs are pure decodes of registered state. Reset therefore
// clears them at once.
module aes_nch_sched
   import aes_pkg::*;
#(
   parameter int N  = 4,
   parameter int NR = AES_NR
) (
   input  logic           clk,
   input  logic           rst,
   aes_nch_sched_if.slave bus
);

   localparam int CW = $clog2(N);

   state_t               state_r;
   state_t               state_nxt_s;
   logic [N-1:0]         grant_mask_r;
   logic [CW-1:0]        slot_s;
   logic [AES_RND_W-1:0] round_s;
   logic                 slot_last_s;
   logic                 round_last_s;
   logic                 cnt_clr_s;
   logic                 cnt_step_s;
   logic                 cnt_round_en_s;
   logic                 start_ok_s;

   assign start_ok_s     = bus.start && (bus.chan_req != '0);
   assign bus.grant_mask = grant_mask_r;

   aes_slot_round_cnt #(
      .N  (N),
      .NR (NR)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr_s),
      .step       (cnt_step_s),
      .round_en   (cnt_round_en_s),
      .slot       (slot_s),
      .round      (round_s),
      .slot_last  (slot_last_s),
      .round_last (round_last_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Snapshot of granted channels, frozen for the whole batch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_mask_r <= '0;
      end else if ((state_r == IDLE) && start_ok_s) begin
         grant_mask_r <= bus.chan_req;
      end else if (state_r == DONE) begin
         grant_mask_r <= '0;
      end else begin
         grant_mask_r <= grant_mask_r;
      end
   end

   // Next-state logic: the slot/round terminal counts pace the phases.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            if (slot_last_s) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = LOAD;
            end
         end
         RUN: begin
            if (slot_last_s && round_last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode: core controls, counter controls and the channel valid flag.
   always_comb begin
      bus.busy       = 1'b0;
      bus.load_en    = 1'b0;
      bus.load_sel   = '0;
      bus.accept     = 1'b0;
      bus.rndNo      = 4'd0;
      bus.enbSB      = 1'b0;
      bus.enbSR      = 1'b0;
      bus.enbMC      = 1'b0;
      bus.enbAR      = 1'b0;
      bus.enbKS      = 1'b0;
      bus.out_valid  = 1'b0;
      bus.out_chan   = '0;
      bus.done       = 1'b0;
      cnt_clr_s      = 1'b0;
      cnt_step_s     = 1'b0;
      cnt_round_en_s = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_clr_s = 1'b1;
         end
         LOAD: begin
            bus.busy     = 1'b1;
            bus.load_en  = 1'b1;
            bus.load_sel = slot_s;
            cnt_step_s   = 1'b1;
         end
         RUN: begin
            bus.busy       = 1'b1;
            bus.accept     = 1'b1;
            bus.rndNo      = round_s;
            bus.out_chan   = slot_s;
            bus.enbAR      = 1'b1;
            bus.enbKS      = 1'b1;
            cnt_step_s     = 1'b1;
            cnt_round_en_s = 1'b1;
            // Round 0 is the initial key add only; the last round skips MixColumns.
            if (round_s == '0) begin
               bus.enbSB = 1'b0;
               bus.enbSR = 1'b0;
               bus.enbMC = 1'b0;
            end else begin
               bus.enbSB = 1'b1;
               bus.enbSR = 1'b1;
               bus.enbMC = !round_last_s;
            end
            bus.out_valid = round_last_s && grant_mask_r[slot_s];
         end
         DONE: begin
            bus.done  = 1'b1;
            cnt_clr_s = 1'b1;
         end
         default: begin
            cnt_clr_s = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_nch_sched.sv
// Self-checking bench for aes_nch_sched (N=4, NR=10).
// A cycle-offset model predicts every output from the batch start time.
// Directed batches also pin the model to hand-computed cycle numbers.
module tb_aes_nch_sched;
   import aes_pkg::*;

   localparam int N        = 4;
   localparam int NR       = AES_NR;
   localparam int RUN_LEN  = (NR + 1) * N;
   localparam int DONE_OFF = N + 1 + RUN_LEN;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_nch_sched_if #(.N(N)) bus();

   aes_nch_sched #(.N(N), .NR(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: a batch is an offset counter started when an idle scheduler accepts start.
   logic         m_active;
   int           m_off;
   logic [N-1:0] m_g;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_off    <= 0;
         m_g      <= '0;
      end else if (m_active) begin
         if (m_off == DONE_OFF) m_active <= 1'b0;
         m_off <= m_off + 1;
      end else if (bus.start && (bus.chan_req != '0)) begin
         m_active <= 1'b1;
         m_off    <= 1;
         m_g      <= bus.chan_req;
      end
   end

   // Compare process: every output against the model, on each falling edge.
   always @(negedge clk) begin
      logic e_busy, e_ld, e_acc, e_sb, e_sr, e_mc, e_ar, e_ks, e_ov, e_done;
      logic [N-1:0] e_gm;
      int e_sel, e_rnd, e_ch, k, r, s;
      if (!rst) begin
         {e_busy, e_ld, e_acc, e_sb, e_sr, e_mc, e_ar, e_ks, e_ov, e_done} = '0;
         e_gm = '0; e_sel = 0; e_rnd = 0; e_ch = 0;
         if (m_active) begin
            e_gm = m_g;
            if (m_off <= N) begin
               e_busy = 1'b1; e_ld = 1'b1; e_sel = m_off - 1;
            end else if (m_off <= N + RUN_LEN) begin
               k = m_off - N - 1; r = k / N; s = k % N;
               e_busy = 1'b1; e_acc = 1'b1; e_rnd = r; e_ch = s;
               e_ar = 1'b1; e_ks = 1'b1;
               e_sb = (r >= 1); e_sr = (r >= 1); e_mc = (r >= 1) && (r < NR);
               e_ov = (r == NR) && m_g[s];
            end else begin
               e_done = 1'b1;
            end
         end
         chk("busy", 32'(bus.busy), 32'(e_busy));
         chk("grant_mask", 32'(bus.grant_mask), 32'(e_gm));
         chk("load_en", 32'(bus.load_en), 32'(e_ld));
         chk("load_sel", 32'(bus.load_sel), 32'(e_sel));
         chk("accept", 32'(bus.accept), 32'(e_acc));
         chk("rndNo", 32'(bus.rndNo), 32'(e_rnd));
         chk("enbSB", 32'(bus.enbSB), 32'(e_sb));
         chk("enbSR", 32'(bus.enbSR), 32'(e_sr));
         chk("enbMC", 32'(bus.enbMC), 32'(e_mc));
         chk("enbAR", 32'(bus.enbAR), 32'(e_ar));
         chk("enbKS", 32'(bus.enbKS), 32'(e_ks));
         chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
         chk("out_chan", 32'(bus.out_chan), 32'(e_ch));
         chk("done", 32'(bus.done), 32'(e_done));
      end
   end

   // Directed-batch event log (cycle 0 = start cycle).
   int          ld_first, ld_last, ld_n, acc_first, acc_last, mc0_n;
   int          ov_n, ov_first, ov_last, done_c, gm_bad;
   logic [31:0] ld_word, ov_word, ov_cyc_word;

   task automatic run_batch(input logic [N-1:0] req, input bit poke, input int rst_at);
      ld_first = -1; ld_last = -1; ld_n = 0; acc_first = -1; acc_last = -1; mc0_n = 0;
      ov_n = 0; ov_first = -1; ov_last = -1; done_c = -1; gm_bad = 0;
      ld_word = '0; ov_word = '0; ov_cyc_word = '0;
      for (int c = 0; c <= 52; c++) begin
         if (c == 0) begin
            bus.start = 1'b1; bus.chan_req = req;
         end else if (poke && c == 20) begin
            bus.start = 1'b1; bus.chan_req = 4'b1111;
         end else begin
            bus.start = 1'b0; bus.chan_req = 4'($urandom);
         end
         @(negedge clk);
         if (!rst) begin
            if (bus.load_en) begin
               if (ld_first < 0) ld_first = c;
               ld_last = c; ld_n++;
               ld_word = {ld_word[29:0], bus.load_sel};
            end
            if (bus.accept) begin
               if (acc_first < 0) acc_first = c;
               acc_last = c;
               if (!bus.enbMC) mc0_n++;
            end
            if (bus.out_valid) begin
               if (ov_first < 0) ov_first = c;
               ov_last = c; ov_n++;
               ov_word     = {ov_word[29:0], bus.out_chan};
               ov_cyc_word = {ov_cyc_word[25:0], 6'(c)};
            end
            if (bus.done) done_c = c;
            if (c >= 1 && c <= 49 && bus.grant_mask != req) gm_bad++;
         end
         if (c == rst_at) begin
            #2 rst = 1'b1;
            #1 chk("async_rst_outputs",
                   32'({bus.busy, bus.grant_mask, bus.load_en, bus.load_sel, bus.accept,
                        bus.rndNo, bus.enbSB, bus.enbSR, bus.enbMC, bus.enbAR, bus.enbKS,
                        bus.out_valid, bus.out_chan, bus.done}), 32'd0);
            @(posedge clk);
            @(posedge clk);
            #2 rst = 1'b0;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.chan_req = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // Idle after reset, then start with an empty request vector is ignored.
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_load_en", 32'(bus.load_en), 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.chan_req = 4'b0000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("empty_req_no_load", 32'({bus.load_en, bus.busy}), 32'd0);
         @(posedge clk); #1;
      end

      // Full grant.
      run_batch(4'b1111, 1'b0, -1);
      chk("full_ld_first", 32'(ld_first), 32'd1);
      chk("full_ld_last", 32'(ld_last), 32'd4);
      chk("full_ld_sel_seq", ld_word, 32'h1B);
      chk("full_acc_first", 32'(acc_first), 32'd5);
      chk("full_acc_last", 32'(acc_last), 32'd48);
      chk("full_mc0_cycles", 32'(mc0_n), 32'd8);
      chk("full_ov_n", 32'(ov_n), 32'd4);
      chk("full_ov_first", 32'(ov_first), 32'd45);
      chk("full_ov_last", 32'(ov_last), 32'd48);
      chk("full_ov_chan_seq", ov_word, 32'h1B);
      chk("full_done", 32'(done_c), 32'd49);
      chk("full_gm_stable", 32'(gm_bad), 32'd0);

      // Partial grant 0101.
      run_batch(4'b0101, 1'b0, -1);
      chk("part_ov_n", 32'(ov_n), 32'd2);
      chk("part_ov_cycles", ov_cyc_word, 32'hB6F);
      chk("part_ov_chan_seq", ov_word, 32'h2);
      chk("part_gm_stable", 32'(gm_bad), 32'd0);
      chk("part_done", 32'(done_c), 32'd49);

      // start/chan_req pulsed mid-batch is ignored.
      run_batch(4'b0011, 1'b1, -1);
      chk("poke_gm_stable", 32'(gm_bad), 32'd0);
      chk("poke_done", 32'(done_c), 32'd49);
      chk("poke_ov_n", 32'(ov_n), 32'd2);

      // Reset mid-batch abandons it, and the next batch runs normally.
      run_batch(4'b1111, 1'b0, 30);
      chk("rst_no_ov", 32'(ov_n), 32'd0);
      chk("rst_no_done", 32'(done_c), 32'hFFFF_FFFF);
      run_batch(4'b1111, 1'b0, -1);
      chk("after_rst_done", 32'(done_c), 32'd49);
      chk("after_rst_ov_n", 32'(ov_n), 32'd4);

      // Random traffic, including back-to-back starts and rare resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
         bus.start = ($urandom_range(0, 2) == 0);
         bus.chan_req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
         @(posedge clk);
         #1;
      end

      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
